// File: rtl/core_pkg.sv
// Shared core definitions: opcode map, sequencer state encoding, opcode class helper.
package core_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned STATE_W  = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    // ALU / control class
    localparam opcode_t OP_NOP               = 5'h00;
    localparam opcode_t OP_ADD               = 5'h01;
    localparam opcode_t OP_SUB               = 5'h02;
    localparam opcode_t OP_AND               = 5'h03;
    localparam opcode_t OP_OR                = 5'h04;
    localparam opcode_t OP_XOR               = 5'h05;
    localparam opcode_t OP_SHL               = 5'h06;
    localparam opcode_t OP_SHR               = 5'h07;
    // Memory class
    localparam opcode_t OP_LOAD_BYTE         = 5'h08;
    localparam opcode_t OP_STORE_BYTE        = 5'h09;
    localparam opcode_t OP_LOAD_TOP_BYTE     = 5'h0A;
    localparam opcode_t OP_STORE_TOP_BYTE    = 5'h0B;
    localparam opcode_t OP_STORE_TOP_BYTE_I  = 5'h0C;
    localparam opcode_t OP_LOAD_LOWER_H_BYTE = 5'h0D;
    localparam opcode_t OP_LOAD_UPPER_H_BYTE = 5'h0E;
    // Branches (taken-ness comes from the decoder's jump_en)
    localparam opcode_t OP_B                 = 5'h10;
    localparam opcode_t OP_BEQ               = 5'h11;
    // Two-phase register exchange
    localparam opcode_t OP_SWAP              = 5'h1F;

    // Sequencer state encoding
    typedef logic [STATE_W-1:0] seq_state_t;

    localparam seq_state_t ST_IDLE     = 3'd0;
    localparam seq_state_t ST_FETCH    = 3'd1;
    localparam seq_state_t ST_EXEC     = 3'd2;
    localparam seq_state_t ST_MEM_WAIT = 3'd3;
    localparam seq_state_t ST_SWAP2    = 3'd4;
    localparam seq_state_t ST_HALT     = 3'd5;

    // True for opcodes that must wait on the data-memory handshake
    function automatic logic is_mem_op(input opcode_t op);
        logic res;
        case (op)
            OP_LOAD_BYTE,
            OP_STORE_BYTE,
            OP_LOAD_TOP_BYTE,
            OP_STORE_TOP_BYTE,
            OP_STORE_TOP_BYTE_I,
            OP_LOAD_LOWER_H_BYTE,
            OP_LOAD_UPPER_H_BYTE: res = 1'b1;
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// MEM_WAIT watchdog: load starts the count at 1, inc advances it, expire_c flags the limit.
module mem_timeout_ctr #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic inc,
    output logic expire_c
);

    localparam int unsigned CTR_W = $clog2(MEM_TIMEOUT + 1);

    logic [CTR_W-1:0] count;

    // Wait-cycle counter; holds at the limit so it can never wrap back into range
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CTR_W'(1);
        end else if (inc && !expire_c) begin
            count <= count + CTR_W'(1);
        end
    end

    assign expire_c = (count == CTR_W'(MEM_TIMEOUT));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: owns the PC, stretches memory ops until ack,
// splits SWAP into two write phases and halts on branch-to-self or PC end.
module instr_sequencer
    import core_pkg::*;
#(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned START_PC    = 0,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  target,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             mem_req,
    output logic             wb_en,
    output logic             swap_phase,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [PC_W-1:0]  PC_START = PC_W'(START_PC);
    localparam logic [PC_W-1:0]  PC_LAST  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;
    logic             commit;
    logic             ctr_load;
    logic             ctr_clear;
    logic             ctr_inc;
    logic             ctr_expire_c;

    mem_timeout_ctr #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timeout_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .clear    (ctr_clear),
        .inc      (ctr_inc),
        .expire_c (ctr_expire_c)
    );

    // State, PC, commit counter and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= PC_START;
            instr_count <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_count <= cnt_nxt;
            err         <= err_nxt;
        end
    end

    // Next-state, strobes and commit resolution
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        cnt_nxt    = instr_count;
        err_nxt    = err;
        ir_load    = 1'b0;
        mem_req    = 1'b0;
        wb_en      = 1'b0;
        swap_phase = 1'b0;
        commit     = 1'b0;
        ctr_load   = 1'b0;
        ctr_clear  = 1'b0;
        ctr_inc    = 1'b0;

        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = PC_START;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_load   = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode == OP_SWAP) begin
                    wb_en     = 1'b1;
                    state_nxt = ST_SWAP2;
                end else if (is_mem_op(opcode)) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        wb_en  = 1'b1;
                        commit = 1'b1;
                    end else begin
                        ctr_load  = 1'b1;
                        state_nxt = ST_MEM_WAIT;
                    end
                end else begin
                    wb_en  = 1'b1;
                    commit = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wb_en     = 1'b1;
                    commit    = 1'b1;
                    ctr_clear = 1'b1;
                end else if (ctr_expire_c) begin
                    state_nxt = ST_HALT;
                    err_nxt   = 1'b1;
                    ctr_clear = 1'b1;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            ST_SWAP2: begin
                wb_en      = 1'b1;
                swap_phase = 1'b1;
                commit     = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Retire: count, then pick halt / branch / fall-through
        if (commit) begin
            if (instr_count != CNT_MAX) begin
                cnt_nxt = instr_count + CNT_W'(1);
            end
            if (jump_en && (target == pc)) begin
                state_nxt = ST_HALT;
            end else if (jump_en) begin
                pc_nxt    = target;
                state_nxt = ST_FETCH;
            end else if (pc == PC_LAST) begin
                state_nxt = ST_HALT;
            end else begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = ST_FETCH;
            end
        end
    end

    // Status decoded from the state register
    always_comb begin
        busy = (state == ST_FETCH) || (state == ST_EXEC) ||
               (state == ST_MEM_WAIT) || (state == ST_SWAP2);
        done = (state == ST_HALT);
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: acts as instruction ROM/decoder and data memory,
// compares observed run behaviour against a program-level reference model.
module tb_instr_sequencer;
    import core_pkg::*;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMO   = 4;
    localparam int          DEPTH = 1 << PC_W;
    localparam int          LIMIT = 3000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [4:0]       opcode;
    logic             jump_en;
    logic [PC_W-1:0]  target;
    logic             mem_ack;
    logic [PC_W-1:0]  pc;
    logic             ir_load;
    logic             mem_req;
    logic             wb_en;
    logic             swap_phase;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] instr_count;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W        (PC_W),
        .START_PC    (0),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .jump_en     (jump_en),
        .target      (target),
        .mem_ack     (mem_ack),
        .pc          (pc),
        .ir_load     (ir_load),
        .mem_req     (mem_req),
        .wb_en       (wb_en),
        .swap_phase  (swap_phase),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .instr_count (instr_count)
    );

    int tests;
    int fails;

    // Program image: opcode, decoder branch result/target, memory ack delay
    opcode_t p_op  [DEPTH];
    bit      p_jmp [DEPTH];
    int      p_tgt [DEPTH];
    int      p_dly [DEPTH];

    opcode_t mem_list [7] = '{OP_LOAD_BYTE, OP_STORE_BYTE, OP_LOAD_TOP_BYTE, OP_STORE_TOP_BYTE,
                              OP_STORE_TOP_BYTE_I, OP_LOAD_LOWER_H_BYTE, OP_LOAD_UPPER_H_BYTE};

    // Observations from one run
    int o_cycles, o_wb, o_mreq, o_swp, o_bad;
    bit o_timeout;
    int o_fetch[$];
    bit s_pre_mreq;
    int s_pc, s_cnt, s_err, s_strobes;

    // Expectations from the reference model
    int e_cycles, e_wb, e_mreq, e_swp, e_pc, e_cnt;
    bit e_err;
    int e_fetch[$];

    function automatic bit in_mem_class(input opcode_t op);
        foreach (mem_list[i]) if (mem_list[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int q_diff(input int a[$], input int b[$]);
        int d = (a.size() == b.size()) ? 0 : 1;
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
        return d;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) begin
            p_op[i] = OP_NOP; p_jmp[i] = 1'b0; p_tgt[i] = 0; p_dly[i] = 0;
        end
    endtask

    // Reference model: walk the program instruction by instruction, summing latencies
    task automatic model_run();
        int p = 0;
        int n = 0;
        e_fetch.delete();
        e_cycles = 0; e_wb = 0; e_mreq = 0; e_swp = 0; e_err = 1'b0;
        for (int step = 0; step < 4096; step++) begin
            e_fetch.push_back(p);
            if (in_mem_class(p_op[p])) begin
                if (p_dly[p] > TMO) begin
                    e_cycles += 2 + TMO; e_mreq += 1 + TMO; e_err = 1'b1;
                    break;
                end
                e_cycles += 2 + p_dly[p]; e_mreq += 1 + p_dly[p]; e_wb += 1;
            end else if (p_op[p] == OP_SWAP) begin
                e_cycles += 3; e_wb += 2; e_swp += 1;
            end else begin
                e_cycles += 2; e_wb += 1;
            end
            n = (n == (1 << CNT_W) - 1) ? n : n + 1;
            if (p_jmp[p] && p_tgt[p] == p) break;
            else if (p_jmp[p]) p = p_tgt[p];
            else if (p == DEPTH - 1) break;
            else p = p + 1;
        end
        e_pc = p; e_cnt = n;
    endtask

    // Pulse start, then play ROM/decoder/memory until HALT (or reset_at / cycle limit)
    task automatic run_engine(input int start_at, input int reset_at);
        int cur = 0;
        int wcnt = 0;
        o_fetch.delete();
        o_cycles = 0; o_wb = 0; o_mreq = 0; o_swp = 0; o_bad = 0; o_timeout = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            if (done) begin
                o_cycles = k; o_timeout = 1'b0;
                if (ir_load || wb_en || mem_req || busy || swap_phase) o_bad++;
                break;
            end
            if (!busy) o_bad++;
            if (ir_load) begin
                cur = int'(pc); o_fetch.push_back(cur); wcnt = 0; mem_ack = 1'b0;
            end else begin
                mem_ack = in_mem_class(p_op[cur]) && (wcnt == p_dly[cur]);
                wcnt++;
            end
            opcode  = p_op[cur];
            jump_en = p_jmp[cur];
            target  = PC_W'(p_tgt[cur]);
            start   = (k == start_at);
            #1;
            if (wb_en) o_wb++;
            if (mem_req) o_mreq++;
            if (wb_en && swap_phase) o_swp++;
            if (swap_phase && !wb_en) o_bad++;
            if (ir_load && (wb_en || mem_req)) o_bad++;
            if (k == reset_at) begin
                s_pre_mreq = mem_req;
                reset = 1'b0;
                #1;
                s_pc = int'(pc); s_cnt = int'(instr_count); s_err = int'(err);
                s_strobes = int'({ir_load, mem_req, wb_en, swap_phase, busy, done});
                o_timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (pc !== '0) begin fails++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        tests++; if (instr_count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_status: got %b expected 00", {busy, done}); end
        tests++; if ({ir_load, mem_req, wb_en, swap_phase} !== 4'b0) begin fails++; $display("FAIL reset_strobes: got %b expected 0000", {ir_load, mem_req, wb_en, swap_phase}); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL idle_after_reset: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_straight_line();
        int exp_q[$] = '{0, 1, 2, 3};
        clear_prog();
        for (int i = 0; i < 3; i++) p_op[i] = OP_ADD;
        p_op[3] = OP_B; p_jmp[3] = 1'b1; p_tgt[3] = 3;
        run_engine(-1, -1);
        tests++; if (o_timeout || o_cycles != 8) begin fails++; $display("FAIL straight_latency: got %0d expected 8", o_cycles); end
        tests++; if (q_diff(o_fetch, exp_q) != 0) begin fails++; $display("FAIL straight_pcs: got %p expected %p", o_fetch, exp_q); end
        tests++; if (instr_count !== 16'd4) begin fails++; $display("FAIL straight_count: got %0d expected 4", instr_count); end
        tests++; if (pc !== 10'd3 || err !== 1'b0) begin fails++; $display("FAIL straight_halt: got pc=%0d err=%b expected pc=3 err=0", pc, err); end
        tests++; if (o_wb != 4 || o_bad != 0) begin fails++; $display("FAIL straight_strobes: got wb=%0d bad=%0d expected wb=4 bad=0", o_wb, o_bad); end
    endtask

    task automatic test_mem_stall();
        int exp_q[$] = '{0, 1};
        clear_prog();
        p_op[0] = OP_STORE_BYTE; p_dly[0] = 3;
        p_op[1] = OP_B; p_jmp[1] = 1'b1; p_tgt[1] = 1;
        run_engine(-1, -1);
        tests++; if (o_mreq != 4) begin fails++; $display("FAIL stall_mem_req: got %0d cycles expected 4", o_mreq); end
        tests++; if (o_wb != 2) begin fails++; $display("FAIL stall_wb: got %0d expected 2", o_wb); end
        tests++; if (q_diff(o_fetch, exp_q) != 0 || o_cycles != 7) begin fails++; $display("FAIL stall_flow: got pcs=%p cycles=%0d expected %p cycles=7", o_fetch, o_cycles, exp_q); end
    endtask

    task automatic test_swap();
        clear_prog();
        p_op[0] = OP_SWAP;
        p_op[1] = OP_B; p_jmp[1] = 1'b1; p_tgt[1] = 1;
        run_engine(-1, -1);
        tests++; if (o_wb != 3 || o_swp != 1) begin fails++; $display("FAIL swap_phases: got wb=%0d phase1=%0d expected wb=3 phase1=1", o_wb, o_swp); end
        tests++; if (o_cycles != 5 || pc !== 10'd1 || o_bad != 0) begin fails++; $display("FAIL swap_flow: got cycles=%0d pc=%0d bad=%0d expected 5 1 0", o_cycles, pc, o_bad); end
    endtask

    task automatic test_branch();
        clear_prog();
        for (int i = 0; i < 5; i++) p_op[i] = OP_ADD;
        p_op[5] = OP_B; p_jmp[5] = 1'b1; p_tgt[5] = 'h20;
        p_op['h20] = OP_B; p_jmp['h20] = 1'b1; p_tgt['h20] = 'h20;
        run_engine(-1, -1);
        tests++; if (o_fetch.size() != 7 || o_fetch[6] != 'h20) begin fails++; $display("FAIL branch_target: got %p expected 0..5 then 32", o_fetch); end
        tests++; if (instr_count !== 16'd7 || o_cycles != 14) begin fails++; $display("FAIL branch_count: got count=%0d cycles=%0d expected 7 14", instr_count, o_cycles); end
    endtask

    task automatic test_timeout();
        clear_prog();
        p_op[0] = OP_B; p_jmp[0] = 1'b1; p_tgt[0] = 'h10;
        p_op['h10] = OP_LOAD_BYTE; p_dly['h10] = 99;
        run_engine(-1, -1);
        tests++; if (err !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL timeout_err: got err=%b done=%b expected 1 1", err, done); end
        tests++; if (instr_count !== 16'd1 || pc !== 10'h10) begin fails++; $display("FAIL timeout_state: got count=%0d pc=%0d expected 1 16", instr_count, pc); end
        tests++; if (o_cycles != 8 || o_mreq != 5 || o_wb != 1) begin fails++; $display("FAIL timeout_timing: got cycles=%0d mreq=%0d wb=%0d expected 8 5 1", o_cycles, o_mreq, o_wb); end
    endtask

    task automatic test_restart_clears_err();
        clear_prog();
        p_op[0] = OP_B; p_jmp[0] = 1'b1; p_tgt[0] = 0;
        run_engine(-1, -1);
        tests++; if (err !== 1'b0 || instr_count !== 16'd1 || o_cycles != 2) begin fails++; $display("FAIL restart: got err=%b count=%0d cycles=%0d expected 0 1 2", err, instr_count, o_cycles); end
    endtask

    task automatic test_ack_at_timeout();
        clear_prog();
        p_op[0] = OP_LOAD_UPPER_H_BYTE; p_dly[0] = TMO;
        p_op[1] = OP_B; p_jmp[1] = 1'b1; p_tgt[1] = 1;
        run_engine(-1, -1);
        tests++; if (err !== 1'b0 || instr_count !== 16'd2 || o_cycles != 2 + TMO + 2) begin fails++; $display("FAIL ack_at_limit: got err=%b count=%0d cycles=%0d expected 0 2 %0d", err, instr_count, o_cycles, 4 + TMO); end
    endtask

    task automatic test_pc_max();
        clear_prog();
        p_op[0] = OP_B; p_jmp[0] = 1'b1; p_tgt[0] = DEPTH - 1;
        p_op[DEPTH-1] = OP_ADD;
        run_engine(-1, -1);
        tests++; if (pc !== 10'h3FF || instr_count !== 16'd2 || o_cycles != 4) begin fails++; $display("FAIL pc_end_halt: got pc=%0d count=%0d cycles=%0d expected 1023 2 4", pc, instr_count, o_cycles); end
    endtask

    task automatic test_start_while_busy();
        clear_prog();
        p_op[0] = OP_STORE_BYTE; p_dly[0] = 3;
        p_op[1] = OP_B; p_jmp[1] = 1'b1; p_tgt[1] = 1;
        run_engine(2, -1);
        tests++; if (o_cycles != 7 || o_fetch.size() != 2 || pc !== 10'd1 || instr_count !== 16'd2) begin fails++; $display("FAIL start_ignored: got cycles=%0d fetches=%0d pc=%0d count=%0d expected 7 2 1 2", o_cycles, o_fetch.size(), pc, instr_count); end
    endtask

    task automatic test_reset_mid_op();
        clear_prog();
        p_op[0] = OP_B; p_jmp[0] = 1'b1; p_tgt[0] = 'h40;
        p_op['h40] = OP_LOAD_BYTE; p_dly['h40] = 99;
        run_engine(-1, 5);
        tests++; if (s_pre_mreq !== 1'b1) begin fails++; $display("FAIL rst_mid_precond: got mem_req=%b expected 1", s_pre_mreq); end
        tests++; if (s_pc != 0 || s_cnt != 0 || s_err != 0 || s_strobes != 0) begin fails++; $display("FAIL rst_mid_abort: got pc=%0d count=%0d err=%0d strobes=%0d expected all 0", s_pc, s_cnt, s_err, s_strobes); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Random programs laid out as a non-revisiting path ending in branch-to-self
    task automatic gen_prog();
        bit used [DEPTH];
        int p = 0;
        int len;
        int r;
        int t;
        clear_prog();
        len = $urandom_range(3, 20);
        for (int i = 0; i < len; i++) begin
            used[p] = 1'b1;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                case ($urandom_range(0, 5))
                    0: p_op[p] = OP_NOP;
                    1: p_op[p] = OP_ADD;
                    2: p_op[p] = OP_SUB;
                    3: p_op[p] = OP_AND;
                    4: p_op[p] = OP_OR;
                    default: p_op[p] = OP_XOR;
                endcase
            end else if (r <= 6) begin
                p_op[p]  = mem_list[$urandom_range(0, 6)];
                p_dly[p] = $urandom_range(0, TMO + 1);
            end else if (r == 7) begin
                p_op[p] = OP_SWAP;
            end else begin
                p_op[p] = OP_B;
            end
            if (p == DEPTH - 1) begin
                if (p_op[p] == OP_B) p_op[p] = OP_ADD;
                break;
            end
            if (i == len - 1) begin
                p_op[p] = OP_B; p_jmp[p] = 1'b1; p_tgt[p] = p;
                break;
            end
            if (p_op[p] == OP_B || used[p+1]) begin
                do t = $urandom_range(0, DEPTH - 1); while (used[t] || t == p);
                p_jmp[p] = 1'b1; p_tgt[p] = t; p = t;
            end else begin
                p = p + 1;
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            gen_prog();
            model_run();
            run_engine(-1, -1);
            tests++; if (o_timeout || o_cycles != e_cycles) begin fails++; $display("FAIL rand%0d_cycles: got %0d expected %0d", n, o_cycles, e_cycles); end
            tests++; if (q_diff(o_fetch, e_fetch) != 0) begin fails++; $display("FAIL rand%0d_pcs: got %0d fetches expected %0d", n, o_fetch.size(), e_fetch.size()); end
            tests++; if (o_wb != e_wb || o_mreq != e_mreq || o_swp != e_swp || o_bad != 0) begin fails++; $display("FAIL rand%0d_strobes: got wb=%0d mreq=%0d swp=%0d bad=%0d expected %0d %0d %0d 0", n, o_wb, o_mreq, o_swp, o_bad, e_wb, e_mreq, e_swp); end
            tests++; if (int'(pc) != e_pc || int'(instr_count) != e_cnt || err !== e_err) begin fails++; $display("FAIL rand%0d_final: got pc=%0d count=%0d err=%b expected %0d %0d %b", n, pc, instr_count, err, e_pc, e_cnt, e_err); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0; start = 1'b0; opcode = OP_NOP; jump_en = 1'b0; target = '0; mem_ack = 1'b0;
        test_reset();
        test_straight_line();
        test_mem_stall();
        test_swap();
        test_branch();
        test_timeout();
        test_restart_clears_err();
        test_ack_at_timeout();
        test_pc_max();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
